// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX arbiter slice.
//   arb_state_t      : arbiter FSM states
//   uart_hdr_t       : one header byte on the UART link
//   HDR_BASE_DEFAULT : default header base; client ID is OR-ed into its low bits
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      DATA   = 2'd2
   } arb_state_t;

   typedef logic [7:0] uart_hdr_t;

   localparam uart_hdr_t HDR_BASE_DEFAULT = 8'hA0;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Client byte-stream bundle plus the UART TX FIFO write port.
//   i_req_valid/i_req_data/i_req_last : client byte offers (client k at [k*DataLength +: DataLength])
//   o_req_ready                       : byte accepted this cycle
//   o_tx_data/o_tx_req                : UART FIFO write
//   i_tx_rdy                          : UART FIFO not full
// slave  = arbiter side, master = client/UART side.
interface uart_tx_arbiter_if #(
   parameter int unsigned NumRequesters = 4,
   parameter int unsigned DataLength    = 8
);
   logic [NumRequesters-1:0]            i_req_valid;
   logic [NumRequesters*DataLength-1:0] i_req_data;
   logic [NumRequesters-1:0]            i_req_last;
   logic [NumRequesters-1:0]            o_req_ready;
   logic [DataLength-1:0]               o_tx_data;
   logic                                o_tx_req;
   logic                                i_tx_rdy;

   modport slave (
      input  i_req_valid, i_req_data, i_req_last, i_tx_rdy,
      output o_req_ready, o_tx_data, o_tx_req
   );

   modport master (
      output i_req_valid, i_req_data, i_req_last, i_tx_rdy,
      input  o_req_ready, o_tx_data, o_tx_req
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   i_req        : request vector
//   i_last_grant : previous winner; search starts one above it, with wrap
//   o_idx        : chosen client (0 when none)
//   o_any        : at least one request present
module rr_arbiter #(
   parameter int unsigned NumRequesters = 4,
   localparam int unsigned IdW = $clog2(NumRequesters)
) (
   input  logic [NumRequesters-1:0] i_req,
   input  logic [IdW-1:0]           i_last_grant,
   output logic [IdW-1:0]           o_idx,
   output logic                     o_any
);
   import uart_pkg::*;

   logic [2*NumRequesters-1:0] w_dbl;

   always_comb begin
      // Doubling the vector and shifting by last+1 puts the search start at bit 0, so wrap-around
      // becomes a plain low-to-high scan.
      w_dbl = {i_req, i_req} >> (32'(i_last_grant) + 32'd1);
      o_idx = '0;
      o_any = 1'b0;
      for (int unsigned j = 0; j < NumRequesters; j++) begin
         if (!o_any && w_dbl[j]) begin
            o_any = 1'b1;
            o_idx = IdW'((32'(i_last_grant) + 32'd1 + j) % NumRequesters);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART TX FIFO write port among NumRequesters byte-stream clients,
// round-robin at packet granularity, with an optional client-ID header byte.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus            : client offers and UART FIFO write port (slave side)
//   o_grant_id     : current owner, valid while o_busy
//   o_busy         : grant active (HEADER or DATA)
//   o_split        : one-cycle pulse after a packet is cut at MaxPacketLen
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NumRequesters = 4,
   parameter int unsigned DataLength    = 8,
   parameter bit          HeaderEn      = 1'b1,
   parameter uart_hdr_t   HeaderBase    = HDR_BASE_DEFAULT,
   parameter int unsigned MaxPacketLen  = 64
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   uart_tx_arbiter_if.slave                 bus,
   output logic [$clog2(NumRequesters)-1:0] o_grant_id,
   output logic                             o_busy,
   output logic                             o_split
);
   localparam int unsigned IdW  = $clog2(NumRequesters);
   localparam int unsigned CntW = $clog2(MaxPacketLen + 1);

   arb_state_t            r_state;
   logic [IdW-1:0]        r_grant_id;
   logic [IdW-1:0]        r_last_grant;
   logic [CntW-1:0]       r_cnt;
   logic                  r_busy;
   logic                  r_split;

   logic [IdW-1:0]        w_pick;
   logic                  w_any;
   logic                  w_valid;
   logic                  w_last;
   logic                  w_xfer;
   logic [DataLength-1:0] w_data;
   uart_hdr_t             w_hdr;

   rr_arbiter #(.NumRequesters(NumRequesters)) u_rr (
      .i_req        (bus.i_req_valid),
      .i_last_grant (r_last_grant),
      .o_idx        (w_pick),
      .o_any        (w_any)
   );

   // Owner's lane selected by compare rather than a variable part-select.
   always_comb begin
      w_valid = 1'b0;
      w_last  = 1'b0;
      w_data  = '0;
      for (int unsigned k = 0; k < NumRequesters; k++) begin
         if (IdW'(k) == r_grant_id) begin
            w_valid = bus.i_req_valid[k];
            w_last  = bus.i_req_last[k];
            w_data  = bus.i_req_data[k*DataLength +: DataLength];
         end
      end
   end

   assign w_hdr  = HeaderBase | uart_hdr_t'(r_grant_id);
   assign w_xfer = (r_state == DATA) && w_valid && bus.i_tx_rdy;

   always_comb begin
      bus.o_req_ready = '0;
      bus.o_tx_req    = 1'b0;
      bus.o_tx_data   = '0;
      unique case (r_state)
         HEADER: begin
            bus.o_tx_req  = bus.i_tx_rdy;
            bus.o_tx_data = DataLength'(w_hdr);
         end
         DATA: begin
            bus.o_tx_req  = w_xfer;
            bus.o_tx_data = w_data;
            for (int unsigned k = 0; k < NumRequesters; k++) begin
               bus.o_req_ready[k] = (IdW'(k) == r_grant_id) && bus.i_tx_rdy;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_grant_id   <= '0;
         r_last_grant <= IdW'(NumRequesters - 1);
         r_cnt        <= '0;
         r_busy       <= 1'b0;
         r_split      <= 1'b0;
      end else begin
         r_split <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_grant_id   <= w_pick;
                  r_last_grant <= w_pick;
                  r_cnt        <= '0;
                  r_busy       <= 1'b1;
                  r_state      <= HeaderEn ? HEADER : DATA;
               end
            end
            HEADER: begin
               if (bus.i_tx_rdy) r_state <= DATA;
            end
            DATA: begin
               if (w_xfer) begin
                  r_cnt <= r_cnt + CntW'(1);
                  if (w_last) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end else if (r_cnt == CntW'(MaxPacketLen - 1)) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                     r_split <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_grant_id = r_grant_id;
   assign o_busy     = r_busy;
   assign o_split    = r_split;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Shares the single TX FIFO write port of the UART among `NumRequesters` byte-stream clients.
- Arbitrates round-robin at packet granularity: a granted client keeps the UART until it sends its last byte or hits `MaxPacketLen`.
- Optionally prepends a one-byte header carrying the client ID so the far end can demultiplex.
- Sits between client logic and the UART's `i_tx_data`/`i_tx_req`/`o_tx_rdy` port.

## Interface

Parameters:
- `NumRequesters`, 4, number of clients (2..16)
- `DataLength`, 8, byte width; must match the UART
- `HeaderEn`, 1'b1, 1 = emit a header byte before each packet
- `HeaderBase`, 8'hA0, header byte = `HeaderBase | id`; the low `$clog2(NumRequesters)` bits of `HeaderBase` must be 0
- `MaxPacketLen`, 64, maximum data bytes per grant (1..256)

Ports:
- `i_clk`  in  1  system clock
- `i_rst_n`  in  1  asynchronous active-low reset
- `i_req_valid`  in  NumRequesters  client has a byte
- `i_req_data`  in  NumRequesters*DataLength  client bytes; client k occupies bits [k*DataLength +: DataLength]
- `i_req_last`  in  NumRequesters  byte is the final byte of the packet
- `o_req_ready`  out  NumRequesters  byte accepted this cycle
- `o_tx_data`  out  DataLength  to UART `i_tx_data`
- `o_tx_req`  out  1  to UART `i_tx_req`; one byte written per high cycle
- `i_tx_rdy`  in  1  from UART `o_tx_rdy` (TX FIFO not full)
- `o_grant_id`  out  $clog2(NumRequesters)  current owner; valid while `o_busy`
- `o_busy`  out  1  a grant is active
- `o_split`  out  1  one-cycle pulse when a packet is truncated at `MaxPacketLen`

## Operation

- State machine with states IDLE, HEADER, DATA (`arb_state_t`).
- **IDLE**
  - If any `i_req_valid` is high, pick the first valid client searching from `(last_grant+1) mod NumRequesters` upward with wrap-around.
  - Register the choice in `o_grant_id`, clear the byte counter and set `last_grant` to it.
  - Move to HEADER if `HeaderEn`, else to DATA.
- **HEADER**
  - `o_tx_data = HeaderBase | o_grant_id` and `o_tx_req = i_tx_rdy`.
  - On `i_tx_rdy` go to DATA; otherwise hold.
  - The header is sent regardless of the client's `i_req_valid`.
- **DATA**, with g = `o_grant_id`:
  - `o_req_ready[g] = i_tx_rdy`; all other ready bits are 0.
  - A transfer is `i_req_valid[g] & i_tx_rdy`.
  - On a transfer: `o_tx_req = 1`, `o_tx_data` = client g's data, and the counter increments.
  - Transfer with `i_req_last[g]` → IDLE.
  - Transfer when counter == `MaxPacketLen-1` with `i_req_last[g]` low → IDLE and pulse `o_split`. The client's remaining bytes go out under a later grant with a fresh header.
  - Transfer that is both the last byte and the `MaxPacketLen`-th byte → IDLE with no `o_split`.
  - A client dropping `i_req_valid` mid-packet does not release the grant. The arbiter waits indefinitely.
- `o_tx_req` is never high in IDLE. It is never high unless `i_tx_rdy` is high, so the TX FIFO is never overflowed.
- `o_req_ready`, `o_tx_req` and `o_tx_data` are combinational from state and inputs. All other state is registered.
- Counter width is `$clog2(MaxPacketLen+1)`. It saturates by construction because it is cleared on every IDLE exit.

## Timing

- Reset values:
  - state = IDLE
  - `o_grant_id` = 0, `last_grant` = NumRequesters-1, so client 0 wins first
  - counter = 0
  - `o_busy` = 0, `o_split` = 0, `o_tx_req` = 0, `o_req_ready` = 0, `o_tx_data` = 0
- Arbitration takes one cycle. If valid is seen in IDLE at edge t:
  - the header is written in cycle t+1 (if `i_tx_rdy`);
  - the first data byte goes out in cycle t+2 at the earliest.
- Throughput: one byte per cycle while `i_tx_rdy` and valid are high.
- Packet turnaround is one IDLE cycle between packets.
- `o_busy` is high in HEADER and DATA.
- `o_split` is registered and is high in the cycle after the truncating transfer.
- Reset asserted mid-packet returns the block to IDLE immediately. The partial packet is abandoned; bytes already written stay in the TX FIFO.

## Structure

- Shared package `uart_pkg` holds:
  - `arb_state_t` (IDLE, HEADER, DATA)
  - a `uart_hdr_t` byte typedef
  - the `HeaderBase` default constant
- Sub-module `rr_arbiter`: combinational round-robin pick from the request vector and `last_grant`, producing the index and an any-request flag.

## Test plan

- **Single client:** client 0 sends 3 bytes 0x11, 0x22, 0x33 (last on 0x33), `i_tx_rdy`=1. Required: `o_tx_req` writes 0xA0, 0x11, 0x22, 0x33 on consecutive cycles, then `o_busy` drops.
- **Round-robin:** clients 1 and 3 both hold 2-byte packets, after reset. Required: order is 0xA1 pkt1, 0xA3 pkt3; when client 1 requests again it wins before client 3's next packet.
- **Backpressure:** `i_tx_rdy`=0 for 5 cycles mid-packet. Required: `o_tx_req`=0, `o_req_ready`=0 and the data holds; no byte is lost or duplicated when `i_tx_rdy` returns.
- **Truncation:** `MaxPacketLen`=4, client 2 streams 6 bytes. Required: 0xA2 + 4 bytes, `o_split` pulse, then a new grant with 0xA2 + 2 bytes. Repeat with the last byte falling exactly on the 4th byte: no `o_split`.
- **Reset mid-packet:** `i_rst_n` is pulled low during DATA. Required: all outputs go to their reset values asynchronously, and the next grant goes to client 0.
- **HeaderEn=0:** client 0 sends 0x55 (last). Required: only 0x55 is written, one cycle after the IDLE arbitration.
